// File: rtl/flash_bus_dispatcher.sv
// flash_bus_dispatcher: pops commands from the command FIFO, issues them on
// the flash bus, streams program beats from the write FIFO and read beats into
// the read FIFO, then posts one result entry per command to the result FIFO.
module flash_bus_dispatcher #(
    parameter int CMD_FIFO_DATA_WIDTH  = 72,
    parameter int WR_FIFO_DATA_WIDTH   = 128,
    parameter int RD_FIFO_DATA_WIDTH   = 136,
    parameter int RSLT_FIFO_DATA_WIDTH = 26,
    parameter int TIMEOUT_CYCLES       = 65535
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic [CMD_FIFO_DATA_WIDTH-1:0]  i_cmd_fifo_data,
    input  logic                            i_cmd_fifo_empty,
    output logic                            o_cmd_fifo_re,
    input  logic [WR_FIFO_DATA_WIDTH-1:0]   i_wr_fifo_data,
    input  logic                            i_wr_fifo_empty,
    output logic                            o_wr_fifo_re,
    output logic [RD_FIFO_DATA_WIDTH-1:0]   o_rd_fifo_data,
    output logic                            o_rd_fifo_we,
    input  logic                            i_rd_fifo_full,
    output logic [RSLT_FIFO_DATA_WIDTH-1:0] o_rslt_fifo_data,
    output logic                            o_rslt_fifo_we,
    input  logic                            i_rslt_fifo_full,
    output logic [CMD_FIFO_DATA_WIDTH-1:0]  o_bus_cmd,
    output logic                            o_bus_cmd_valid,
    input  logic                            i_bus_cmd_ready,
    output logic [WR_FIFO_DATA_WIDTH-1:0]   o_bus_wdata,
    output logic                            o_bus_wdata_valid,
    input  logic                            i_bus_wdata_ready,
    input  logic [RD_FIFO_DATA_WIDTH-1:0]   i_bus_rdata,
    input  logic                            i_bus_rdata_valid,
    output logic                            o_bus_rdata_ready,
    input  logic                            i_bus_done,
    input  logic [7:0]                      i_bus_status,
    output logic                            o_busy
);

    typedef enum logic [3:0] {
        IDLE,
        FETCH,
        DECODE,
        ISSUE,
        WDATA_RD,
        WDATA_TX,
        RDATA,
        WAIT_DONE,
        RESULT
    } state_t;

    localparam logic [3:0]  OP_READ    = 4'd1;
    localparam logic [3:0]  OP_PROGRAM = 4'd2;
    localparam logic [3:0]  OP_ERASE   = 4'd3;
    // Watchdog value seen in the last WAIT_DONE cycle before giving up
    localparam logic [15:0] WDOG_LAST  = 16'(TIMEOUT_CYCLES - 1);

    state_t                           state;
    logic [CMD_FIFO_DATA_WIDTH-1:0]   cmd_reg;
    logic [7:0]                       beat_cnt;
    logic [15:0]                      wdog;
    logic [7:0]                       status;
    logic                             err_illegal;
    logic                             err_timeout;
    // Set on the cycle the write FIFO re is issued; next cycle its dout is valid
    logic                             wr_pending;

    logic [3:0]  cmd_op;
    logic [3:0]  cmd_tag;
    logic [7:0]  cmd_len;
    logic        op_legal;
    logic        cmd_illegal;
    logic        rdata_hs;
    logic [7:0]  beats_xfer;
    logic [25:0] rslt_word;

    assign cmd_op  = cmd_reg[71:68];
    assign cmd_tag = cmd_reg[67:64];
    assign cmd_len = cmd_reg[63:56];

    assign op_legal    = (cmd_op == OP_READ) || (cmd_op == OP_PROGRAM) || (cmd_op == OP_ERASE);
    assign cmd_illegal = !op_legal || ((cmd_len == 8'd0) && (cmd_op != OP_ERASE));

    // FIFO strobes are combinational so a re lands on the edge that leaves the
    // requesting state, and a we can never coincide with a full flag.
    assign o_cmd_fifo_re  = (state == IDLE) && !i_cmd_fifo_empty && !i_rst;
    assign o_wr_fifo_re   = (state == WDATA_RD) && !wr_pending && !i_wr_fifo_empty;
    assign o_rslt_fifo_we = (state == RESULT) && !i_rslt_fifo_full;

    assign o_bus_cmd_valid   = (state == ISSUE);
    assign o_bus_cmd         = o_bus_cmd_valid ? cmd_reg : '0;
    assign o_bus_wdata_valid = (state == WDATA_TX);

    // Read path is a pass-through: bus beats go straight into the read FIFO
    assign o_bus_rdata_ready = (state == RDATA) && !i_rd_fifo_full;
    assign rdata_hs          = o_bus_rdata_ready && i_bus_rdata_valid;
    assign o_rd_fifo_we      = rdata_hs;
    assign o_rd_fifo_data    = rdata_hs ? i_bus_rdata : '0;

    assign o_busy = (state != IDLE);

    // Beats actually moved: only data-carrying commands that passed decode count
    always_comb begin
        beats_xfer = 8'd0;
        if (!err_illegal && ((cmd_op == OP_READ) || (cmd_op == OP_PROGRAM)))
            beats_xfer = cmd_len - beat_cnt;
    end

    assign rslt_word        = {cmd_tag, cmd_op, status, beats_xfer, err_illegal, err_timeout};
    assign o_rslt_fifo_data = o_rslt_fifo_we ? rslt_word : '0;

    // Command sequencer: fetch, decode, bus transfer, completion wait, result post
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= IDLE;
            cmd_reg     <= '0;
            beat_cnt    <= 8'd0;
            wdog        <= 16'd0;
            status      <= 8'd0;
            err_illegal <= 1'b0;
            err_timeout <= 1'b0;
            wr_pending  <= 1'b0;
            o_bus_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!i_cmd_fifo_empty)
                        state <= FETCH;
                end
                FETCH: begin
                    cmd_reg <= i_cmd_fifo_data;
                    state   <= DECODE;
                end
                DECODE: begin
                    beat_cnt    <= cmd_len;
                    status      <= 8'd0;
                    err_timeout <= 1'b0;
                    if (cmd_illegal) begin
                        err_illegal <= 1'b1;
                        state       <= RESULT;
                    end else begin
                        err_illegal <= 1'b0;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (i_bus_cmd_ready) begin
                        if (cmd_op == OP_PROGRAM) begin
                            wr_pending <= 1'b0;
                            state      <= WDATA_RD;
                        end else if (cmd_op == OP_READ) begin
                            state <= RDATA;
                        end else begin
                            wdog  <= 16'd0;
                            state <= WAIT_DONE;
                        end
                    end
                end
                WDATA_RD: begin
                    if (wr_pending) begin
                        o_bus_wdata <= i_wr_fifo_data;
                        wr_pending  <= 1'b0;
                        state       <= WDATA_TX;
                    end else if (!i_wr_fifo_empty) begin
                        wr_pending <= 1'b1;
                    end
                end
                WDATA_TX: begin
                    if (i_bus_wdata_ready) begin
                        beat_cnt <= beat_cnt - 8'd1;
                        if (beat_cnt == 8'd1) begin
                            wdog  <= 16'd0;
                            state <= WAIT_DONE;
                        end else begin
                            state <= WDATA_RD;
                        end
                    end
                end
                RDATA: begin
                    if (rdata_hs) begin
                        beat_cnt <= beat_cnt - 8'd1;
                        if (beat_cnt == 8'd1) begin
                            wdog  <= 16'd0;
                            state <= WAIT_DONE;
                        end
                    end
                end
                WAIT_DONE: begin
                    // A done pulse in the final watchdog cycle still wins
                    if (i_bus_done) begin
                        status <= i_bus_status;
                        state  <= RESULT;
                    end else if (wdog == WDOG_LAST) begin
                        err_timeout <= 1'b1;
                        status      <= 8'hFF;
                        state       <= RESULT;
                    end else begin
                        wdog <= wdog + 16'd1;
                    end
                end
                RESULT: begin
                    if (!i_rslt_fifo_full) begin
                        err_illegal <= 1'b0;
                        err_timeout <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/flash_bus_dispatcher.md
FLASH_BUS_DISPATCHER -- requirements
Module: flash_bus_dispatcher

Interface
REQ-001 Parameters, one per line: name, default, meaning:
  CMD_FIFO_DATA_WIDTH, 72, command entry width
  WR_FIFO_DATA_WIDTH, 128, program data beat width
  RD_FIFO_DATA_WIDTH, 136, read data beat width (data + ECC/meta)
  RSLT_FIFO_DATA_WIDTH, 26, result entry width
  TIMEOUT_CYCLES, 65535, bus-done watchdog limit (16-bit)
REQ-002 Ports, one per line: name, direction, width, meaning. Clock and reset come first. There is one clock, i_clk. Reset is i_rst, which is asynchronous and active-high.
  i_clk  in  1  system clock
  i_rst  in  1  async active-high reset
  i_cmd_fifo_data  in  72  command FIFO dout
  i_cmd_fifo_empty  in  1  command FIFO empty
  o_cmd_fifo_re  out  1  command FIFO read enable
  i_wr_fifo_data  in  128  write FIFO dout
  i_wr_fifo_empty  in  1  write FIFO empty
  o_wr_fifo_re  out  1  write FIFO read enable
  o_rd_fifo_data  out  136  read FIFO din
  o_rd_fifo_we  out  1  read FIFO write enable
  i_rd_fifo_full  in  1  read FIFO full
  o_rslt_fifo_data  out  26  result FIFO din
  o_rslt_fifo_we  out  1  result FIFO write enable
  i_rslt_fifo_full  in  1  result FIFO full
  o_bus_cmd  out  72  command to flash bus
  o_bus_cmd_valid / i_bus_cmd_ready  out/in  1  command handshake
  o_bus_wdata  out  128  program beat to bus
  o_bus_wdata_valid / i_bus_wdata_ready  out/in  1  program-data handshake
  i_bus_rdata  in  136  read beat from bus
  i_bus_rdata_valid / o_bus_rdata_ready  in/out  1  read-data handshake
  i_bus_done  in  1  single-cycle operation-complete pulse
  i_bus_status  in  8  bus status, valid with i_bus_done
  o_busy  out  1  high whenever state is not IDLE

Function
REQ-003 The command FIFO fields are: [71:68] opcode, [67:64] tag, [63:56] LEN (number of beats), [47:0] address. The opcode encoding is 1=READ, 2=PROGRAM, 3=ERASE.
REQ-004 All FIFOs are standard mode. Dout is valid on the cycle after the re pulse.
REQ-005 States: IDLE, FETCH, DECODE, ISSUE, WDATA_RD, WDATA_TX, RDATA, WAIT_DONE, RESULT.
REQ-006 IDLE: when i_cmd_fifo_empty=0, pulse o_cmd_fifo_re for 1 cycle and go to FETCH.
REQ-007 FETCH: latch i_cmd_fifo_data into the command register and go to DECODE.
REQ-008 DECODE: an illegal opcode, or LEN=0 with READ or PROGRAM, goes to RESULT with err_illegal=1. Every other command goes to ISSUE. ERASE ignores LEN.
REQ-009 ISSUE: hold o_bus_cmd_valid=1 with o_bus_cmd = the command register until i_bus_cmd_ready=1. Then PROGRAM goes to WDATA_RD, READ goes to RDATA, and ERASE goes to WAIT_DONE.
REQ-010 The beat counter loads LEN in DECODE. It decrements on each completed data handshake.
REQ-011 WDATA_RD: when i_wr_fifo_empty=0, pulse o_wr_fifo_re. On the next cycle, latch i_wr_fifo_data into o_bus_wdata and go to WDATA_TX. The maximum program rate is one beat per 3 cycles.
REQ-012 WDATA_TX: hold o_bus_wdata_valid=1 until i_bus_wdata_ready=1. If the counter is 1 at the handshake, go to WAIT_DONE; otherwise go to WDATA_RD.
REQ-013 RDATA: o_bus_rdata_ready = ~i_rd_fifo_full (combinational). On each handshake, o_rd_fifo_we=1 in the same cycle and o_rd_fifo_data = i_bus_rdata. On the last beat, go to WAIT_DONE.
REQ-014 A 16-bit watchdog clears on entry to WAIT_DONE.
REQ-015 WAIT_DONE:
  - i_bus_done=1 captures i_bus_status and goes to RESULT.
  - If the watchdog reaches TIMEOUT_CYCLES first, set err_timeout=1 and status=8'hFF, then go to RESULT.
  - An i_bus_done arriving on the same cycle as the timeout wins (no timeout flagged).
REQ-016 Result fields: [25:22] tag, [21:18] opcode, [17:10] status, [9:2] beats transferred (LEN minus the remaining count; 0 for ERASE and illegal), [1] err_illegal, [0] err_timeout.
REQ-017 RESULT: when i_rslt_fifo_full=0, pulse o_rslt_fifo_we for 1 cycle with the result, clear the error flags, and go to IDLE. While the FIFO is full, stall with no pulse.
REQ-018 Full and empty stalls:
  - The write FIFO being empty stalls WDATA_RD.
  - The read FIFO being full stalls RDATA (back-pressure to the bus).
  - Stalls have no timeout.
REQ-019 Every FIFO re and we is a single-cycle pulse. No re is issued while the corresponding empty flag is 1, and no we is issued while the corresponding full flag is 1.
REQ-020 i_bus_done outside WAIT_DONE is ignored.

Reset
REQ-021 While i_rst=1, all of the following hold immediately, without waiting for a clock:
  - state=IDLE;
  - every valid, ready, re and we output is 0; o_busy=0;
  - o_bus_cmd, o_bus_wdata, o_rd_fifo_data and o_rslt_fifo_data are 0;
  - the counters and error flags are 0.
REQ-022 A reset asserted mid-command abandons that command. No result is written for it, and the first command after reset is fetched fresh.

Verification
REQ-023 Each of the following scenarios shall be covered by a directed test:
  - PROGRAM: tag=5, LEN=4, 4 words in the write FIFO, bus always ready, done with status=8'h00 -> 4 wdata handshakes with the words in order; result = {5,2,8'h00,8'd4,0,0}; o_busy returns to 0.
  - READ: LEN=3, i_rd_fifo_full held for 10 cycles mid-burst -> o_bus_rdata_ready=0 during the hold; exactly 3 rd_fifo writes; beats field=3.
  - Opcode 4'h7 -> no bus command is issued; result err_illegal=1, beats=0, status=0.
  - ERASE with i_bus_done never asserted -> exactly TIMEOUT_CYCLES cycles after entering WAIT_DONE, result err_timeout=1, status=8'hFF.
  - Result FIFO full for 20 cycles at RESULT -> no we pulse while full; exactly one pulse after full deasserts.
  - i_rst asserted during WDATA_TX of beat 2 of 4 -> all outputs 0 immediately; no result write; the next queued command is processed normally.
